// File: rtl/cache_axi_arbiter.sv
// cache_axi_arbiter: shares one AXI line port between ICache refills, DCache refills and DCache writebacks (ic_rd_*/ic_ret_*, dc_rd_*/dc_ret_*, dc_wr_* in; m_rd_*/m_ret_*/m_wr_* out to AXI)
module cache_axi_arbiter #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 128
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ic_rd_req,
  input  logic [ADDR_W-1:0] ic_rd_addr,
  output logic              ic_rd_rdy,
  output logic              ic_ret_valid,
  output logic [LINE_W-1:0] ic_ret_data,
  input  logic              dc_rd_req,
  input  logic [ADDR_W-1:0] dc_rd_addr,
  output logic              dc_rd_rdy,
  output logic              dc_ret_valid,
  output logic [LINE_W-1:0] dc_ret_data,
  input  logic              dc_wr_req,
  input  logic [ADDR_W-1:0] dc_wr_addr,
  input  logic [LINE_W-1:0] dc_wr_data,
  output logic              dc_wr_rdy,
  output logic              dc_wr_valid,
  output logic              m_rd_req,
  output logic [ADDR_W-1:0] m_rd_addr,
  input  logic              m_rd_rdy,
  input  logic              m_ret_valid,
  input  logic [LINE_W-1:0] m_ret_data,
  output logic              m_wr_req,
  output logic [ADDR_W-1:0] m_wr_addr,
  output logic [LINE_W-1:0] m_wr_data,
  input  logic              m_wr_rdy,
  input  logic              m_wr_valid
);
  typedef enum logic [1:0] {R_IDLE, R_IC, R_DC} rstate_t;
  typedef enum logic [1:0] {W_IDLE, W_REQ, W_WAIT} wstate_t;
  rstate_t r_q, r_d;
  wstate_t w_q, w_d;
  logic last_dc_q, last_dc_d;
  logic [ADDR_W-1:0] wb_addr_q, wb_addr_d;
  logic [LINE_W-1:0] wb_data_q, wb_data_d;
  logic hazard, ic_el, dc_el, pick_dc, acc;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_q       <= R_IDLE;
      w_q       <= W_IDLE;
      last_dc_q <= 1'b0;
      wb_addr_q <= '0;
      wb_data_q <= '0;
    end else begin
      r_q       <= r_d;
      w_q       <= w_d;
      last_dc_q <= last_dc_d;
      wb_addr_q <= wb_addr_d;
      wb_data_q <= wb_data_d;
    end
  always_comb begin
    hazard       = (w_q != W_IDLE) && (dc_rd_addr[ADDR_W-1:4] == wb_addr_q[ADDR_W-1:4]);
    ic_el        = ic_rd_req;
    dc_el        = dc_rd_req && !hazard;
    pick_dc      = dc_el && (!ic_el || !last_dc_q);
    m_rd_req     = !rst && (r_q == R_IDLE) && (ic_el || dc_el);
    m_rd_addr    = pick_dc ? dc_rd_addr : ic_rd_addr;
    acc          = m_rd_req && m_rd_rdy;
    ic_rd_rdy    = acc && !pick_dc;
    dc_rd_rdy    = acc && pick_dc;
    ic_ret_valid = (r_q == R_IC) && m_ret_valid;
    dc_ret_valid = (r_q == R_DC) && m_ret_valid;
    ic_ret_data  = m_ret_data;
    dc_ret_data  = m_ret_data;
    last_dc_d    = acc ? pick_dc : last_dc_q;
    r_d          = acc ? (pick_dc ? R_DC : R_IC) : (r_q != R_IDLE && m_ret_valid) ? R_IDLE : r_q;
  end
  always_comb begin
    dc_wr_rdy   = !rst && (w_q == W_IDLE);
    dc_wr_valid = (w_q == W_WAIT) && m_wr_valid;
    m_wr_req    = (w_q == W_REQ);
    m_wr_addr   = wb_addr_q;
    m_wr_data   = wb_data_q;
    wb_addr_d   = wb_addr_q;
    wb_data_d   = wb_data_q;
    w_d         = w_q;
    if (w_q == W_IDLE && dc_wr_req) begin
      wb_addr_d = dc_wr_addr;
      wb_data_d = dc_wr_data;
      w_d       = W_REQ;
    end else if (w_q == W_REQ && m_wr_rdy) w_d = W_WAIT;
    else if (dc_wr_valid) w_d = W_IDLE;
  end
endmodule

// File: tb/tb_cache_axi_arbiter.sv
// tb_cache_axi_arbiter: directed and randomized checks of cache_axi_arbiter against a transaction-level model
module tb_cache_axi_arbiter;
  logic clk = 0, rst;
  logic ic_rd_req, ic_rd_rdy, ic_ret_valid, dc_rd_req, dc_rd_rdy, dc_ret_valid;
  logic dc_wr_req, dc_wr_rdy, dc_wr_valid, m_rd_req, m_rd_rdy, m_ret_valid, m_wr_req, m_wr_rdy, m_wr_valid;
  logic [31:0] ic_rd_addr, dc_rd_addr, dc_wr_addr, m_rd_addr, m_wr_addr;
  logic [127:0] ic_ret_data, dc_ret_data, dc_wr_data, m_ret_data, m_wr_data;
  int checks = 0, errors = 0;
  int rown;
  bit last_dc;
  int wph;
  logic [31:0] wba;
  logic [127:0] wbd;
  bit e_mrq, e_icr, e_dcr, e_icv, e_dcv, e_wrdy, e_mwr, e_wv;
  logic [31:0] e_addr;
  always #5 clk = ~clk;
  cache_axi_arbiter dut (
    .clk(clk), .rst(rst),
    .ic_rd_req(ic_rd_req), .ic_rd_addr(ic_rd_addr), .ic_rd_rdy(ic_rd_rdy),
    .ic_ret_valid(ic_ret_valid), .ic_ret_data(ic_ret_data),
    .dc_rd_req(dc_rd_req), .dc_rd_addr(dc_rd_addr), .dc_rd_rdy(dc_rd_rdy),
    .dc_ret_valid(dc_ret_valid), .dc_ret_data(dc_ret_data),
    .dc_wr_req(dc_wr_req), .dc_wr_addr(dc_wr_addr), .dc_wr_data(dc_wr_data),
    .dc_wr_rdy(dc_wr_rdy), .dc_wr_valid(dc_wr_valid),
    .m_rd_req(m_rd_req), .m_rd_addr(m_rd_addr), .m_rd_rdy(m_rd_rdy),
    .m_ret_valid(m_ret_valid), .m_ret_data(m_ret_data),
    .m_wr_req(m_wr_req), .m_wr_addr(m_wr_addr), .m_wr_data(m_wr_data),
    .m_wr_rdy(m_wr_rdy), .m_wr_valid(m_wr_valid)
  );
  task automatic chk(string tag, logic [127:0] got, logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask
  task automatic predict();
    bit haz, ice, dce, dcwin;
    haz = wph != 0 && dc_rd_addr[31:4] == wba[31:4];
    ice = ic_rd_req;
    dce = dc_rd_req && !haz;
    if (ice && dce) dcwin = !last_dc;
    else dcwin = dce;
    e_mrq  = rown == 0 && (ice || dce);
    e_addr = dcwin ? dc_rd_addr : ic_rd_addr;
    e_icr  = e_mrq && m_rd_rdy && !dcwin;
    e_dcr  = e_mrq && m_rd_rdy && dcwin;
    e_icv  = rown == 1 && m_ret_valid;
    e_dcv  = rown == 2 && m_ret_valid;
    e_wrdy = wph == 0;
    e_mwr  = wph == 1;
    e_wv   = wph == 2 && m_wr_valid;
  endtask
  task automatic step();
    #1;
    predict();
    chk("m_rd_req", m_rd_req, e_mrq);
    if (e_mrq) chk("m_rd_addr", m_rd_addr, e_addr);
    chk("ic_rd_rdy", ic_rd_rdy, e_icr);
    chk("dc_rd_rdy", dc_rd_rdy, e_dcr);
    chk("ic_ret_valid", ic_ret_valid, e_icv);
    chk("dc_ret_valid", dc_ret_valid, e_dcv);
    chk("ic_ret_data", ic_ret_data, m_ret_data);
    chk("dc_ret_data", dc_ret_data, m_ret_data);
    chk("dc_wr_rdy", dc_wr_rdy, e_wrdy);
    chk("m_wr_req", m_wr_req, e_mwr);
    if (e_mwr) begin
      chk("m_wr_addr", m_wr_addr, wba);
      chk("m_wr_data", m_wr_data, wbd);
    end
    chk("dc_wr_valid", dc_wr_valid, e_wv);
    if (e_icr) begin rown = 1; last_dc = 0; end
    else if (e_dcr) begin rown = 2; last_dc = 1; end
    else if (rown != 0 && m_ret_valid) rown = 0;
    if (wph == 0 && dc_wr_req) begin wba = dc_wr_addr; wbd = dc_wr_data; wph = 1; end
    else if (wph == 1 && m_wr_rdy) wph = 2;
    else if (wph == 2 && m_wr_valid) wph = 0;
    @(negedge clk);
  endtask
  task automatic do_reset();
    rst = 1;
    #1;
    chk("rst m_rd_req", m_rd_req, 0);
    chk("rst ic_rd_rdy", ic_rd_rdy, 0);
    chk("rst dc_rd_rdy", dc_rd_rdy, 0);
    chk("rst ic_ret_valid", ic_ret_valid, 0);
    chk("rst dc_ret_valid", dc_ret_valid, 0);
    chk("rst dc_wr_valid", dc_wr_valid, 0);
    chk("rst m_wr_req", m_wr_req, 0);
    chk("rst dc_wr_rdy", dc_wr_rdy, 0);
    rown = 0; last_dc = 0; wph = 0; wba = '0; wbd = '0;
    ic_rd_req = 0; dc_rd_req = 0; dc_wr_req = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 0;
  endtask
  function automatic logic [31:0] raddr();
    logic [31:0] b[3] = '{32'h3000, 32'h4000, 32'h1000};
    return b[$urandom % 3] | ($urandom % 16);
  endfunction
  initial begin
    rst = 1; ic_rd_req = 0; dc_rd_req = 0; dc_wr_req = 0;
    ic_rd_addr = 0; dc_rd_addr = 0; dc_wr_addr = 0; dc_wr_data = 0;
    m_rd_rdy = 0; m_ret_valid = 0; m_ret_data = 0; m_wr_rdy = 0; m_wr_valid = 0;
    @(negedge clk);
    do_reset();
    // tie goes to DC first, then IC on the next arbitration
    ic_rd_req = 1; ic_rd_addr = 32'h1000; dc_rd_req = 1; dc_rd_addr = 32'h2000; m_rd_rdy = 1;
    #1 chk("tie addr", m_rd_addr, 32'h2000);
    chk("tie dc_rdy", dc_rd_rdy, 1);
    step();
    dc_rd_req = 0;
    step();
    m_ret_valid = 1; m_ret_data = 128'hdead_beef;
    #1 chk("dc ret", dc_ret_valid, 1);
    chk("ic no ret", ic_ret_valid, 0);
    step();
    m_ret_valid = 0;
    #1 chk("ic next addr", m_rd_addr, 32'h1000);
    chk("ic next rdy", ic_rd_rdy, 1);
    step();
    ic_rd_req = 0; m_ret_valid = 1;
    step();
    m_ret_valid = 0;
    // write hazard blocks DC read of same line until write done
    dc_wr_req = 1; dc_wr_addr = 32'h3000; dc_wr_data = 128'h1234;
    step();
    dc_wr_req = 0; dc_rd_req = 1; dc_rd_addr = 32'h3008;
    #1 chk("haz blk", m_rd_req, 0);
    step();
    m_wr_rdy = 1;
    step();
    m_wr_rdy = 0;
    step();
    m_wr_valid = 1;
    #1 chk("wr done", dc_wr_valid, 1);
    chk("haz still", m_rd_req, 0);
    step();
    m_wr_valid = 0;
    #1 chk("haz clear", dc_rd_rdy, 1);
    step();
    dc_rd_req = 0;
    // reset while DC read outstanding with return pending
    m_ret_valid = 1;
    do_reset();
    m_ret_valid = 0;
    ic_rd_req = 1; ic_rd_addr = 32'h1000; m_rd_rdy = 1;
    #1 chk("post rst ic", ic_rd_rdy, 1);
    step();
    ic_rd_req = 0; m_ret_valid = 1;
    step();
    m_ret_valid = 0;
    for (int i = 0; i < 4000; i++) begin
      m_rd_rdy = $urandom % 2; m_ret_valid = ($urandom % 4) == 0; m_wr_rdy = $urandom % 2;
      m_wr_valid = ($urandom % 3) == 0;
      m_ret_data = {$urandom, $urandom, $urandom, $urandom};
      if (!ic_rd_req && $urandom % 3 == 0) begin ic_rd_req = 1; ic_rd_addr = raddr(); end
      if (!dc_rd_req && $urandom % 3 == 0) begin dc_rd_req = 1; dc_rd_addr = raddr(); end
      if (!dc_wr_req && $urandom % 4 == 0) begin
        dc_wr_req = 1; dc_wr_addr = raddr(); dc_wr_data = {$urandom, $urandom, $urandom, $urandom};
      end
      if ($urandom % 500 == 0) do_reset();
      else begin
        bit wacc;
        wacc = wph == 0 && dc_wr_req;
        step();
        if (e_icr) ic_rd_req = 0;
        if (e_dcr) dc_rd_req = 0;
        if (wacc) dc_wr_req = 0;
      end
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
